// File: rtl/instr_stat_if.sv
// Instruction-statistics bus: retire/halt/clear/readout controls toward the
// block and the counter, readout and state values back from it.
interface instr_stat_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned CYC_W = 32
);
  logic [5:0]       op;
  logic             valid;
  logic             halt;
  logic             clr;
  logic [2:0]       sel;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] i_cnt;
  logic [CNT_W-1:0] j_cnt;
  logic [CNT_W-1:0] o_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [31:0]      rd_data;
  logic [1:0]       state;

  modport master (
    output op, valid, halt, clr, sel,
    input  r_cnt, i_cnt, j_cnt, o_cnt, cyc_cnt, rd_data, state
  );

  modport slave (
    input  op, valid, halt, clr, sel,
    output r_cnt, i_cnt, j_cnt, o_cnt, cyc_cnt, rd_data, state
  );
endinterface

// File: rtl/instr_stat_ctrl.sv
// Retired-instruction statistics: per-class saturating counters, a RUN-cycle
// counter and a registered readout mux, gated by an IDLE/RUN/HALTED FSM.
module instr_stat_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned CYC_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  instr_stat_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] r_q, i_q, j_q, o_q;
  logic [CYC_W-1:0] cyc_q;
  logic [31:0]      rd_q;

  logic             is_r_c, is_i_c, is_j_c;
  logic             count_en_c;
  logic [31:0]      total_c;
  logic [31:0]      rd_c;

  // Opcode class decode; anything not R/I/J lands in "other".
  always_comb begin
    is_r_c = 1'b0;
    is_i_c = 1'b0;
    is_j_c = 1'b0;
    case (bus.op)
      6'b000000: is_r_c = 1'b1;
      6'b000010,
      6'b000011: is_j_c = 1'b1;
      6'b000100, 6'b000101, 6'b001000, 6'b001001, 6'b001010,
      6'b001100, 6'b001101, 6'b100011, 6'b101011: is_i_c = 1'b1;
      default: ;
    endcase
  end

  assign count_en_c = bus.valid && !bus.clr && (st != HALTED);
  assign total_c    = 32'(r_q) + 32'(i_q) + 32'(j_q) + 32'(o_q);

  always_comb begin
    rd_c = 32'd0;
    case (bus.sel)
      3'd0:    rd_c = 32'(cyc_q);
      3'd1:    rd_c = 32'(r_q);
      3'd2:    rd_c = 32'(i_q);
      3'd3:    rd_c = 32'(j_q);
      3'd4:    rd_c = 32'(o_q);
      3'd5:    rd_c = total_c;
      default: rd_c = 32'd0;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      r_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      o_q   <= '0;
      cyc_q <= '0;
      rd_q  <= '0;
    end else begin
      rd_q <= rd_c;
      if (bus.clr) begin
        st    <= IDLE;
        r_q   <= '0;
        i_q   <= '0;
        j_q   <= '0;
        o_q   <= '0;
        cyc_q <= '0;
      end else begin
        case (st)
          IDLE: begin
            if (bus.halt)       st <= HALTED;
            else if (bus.valid) st <= RUN;
          end
          RUN: begin
            // The halting cycle is still a RUN cycle and is counted.
            if (!(&cyc_q)) cyc_q <= cyc_q + CYC_W'(1);
            if (bus.halt)  st <= HALTED;
          end
          HALTED: ;
          default: st <= IDLE;
        endcase
        if (count_en_c) begin
          if (is_r_c)      r_q <= sat_inc(r_q);
          else if (is_i_c) i_q <= sat_inc(i_q);
          else if (is_j_c) j_q <= sat_inc(j_q);
          else             o_q <= sat_inc(o_q);
        end
      end
    end
  end

  assign bus.state   = st;
  assign bus.r_cnt   = r_q;
  assign bus.i_cnt   = i_q;
  assign bus.j_cnt   = j_q;
  assign bus.o_cnt   = o_q;
  assign bus.cyc_cnt = cyc_q;
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_instr_stat_ctrl.sv
// Bench for instr_stat_ctrl: a default-width and a 4-bit-counter instance share
// the same stimulus and are compared against a per-width reference model.
module tb_instr_stat_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  instr_stat_if #(.CNT_W(16), .CYC_W(32)) b16 ();
  instr_stat_if #(.CNT_W(4),  .CYC_W(32)) b4 ();

  instr_stat_ctrl #(.CNT_W(16), .CYC_W(32)) u_wide  (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  instr_stat_ctrl #(.CNT_W(4),  .CYC_W(32)) u_small (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: [inst][class] with class 0=R 1=I 2=J 3=other; state 0/1/2.
  int unsigned mcnt [2][4];
  int unsigned mmax [2];
  int unsigned mcyc;
  int unsigned mstate;
  int unsigned mrd [2];

  logic [5:0] op_pool [14];

  function automatic int unsigned op_class(input logic [5:0] op);
    if (op == 6'd0) return 0;
    if (op == 6'd2 || op == 6'd3) return 2;
    if (op == 6'd4 || op == 6'd5 || op == 6'd8 || op == 6'd9 || op == 6'd10 ||
        op == 6'd12 || op == 6'd13 || op == 6'd35 || op == 6'd43) return 1;
    return 3;
  endfunction

  function automatic int unsigned readout(input int k, input logic [2:0] sel);
    case (sel)
      3'd0: return mcyc;
      3'd1: return mcnt[k][0];
      3'd2: return mcnt[k][1];
      3'd3: return mcnt[k][2];
      3'd4: return mcnt[k][3];
      3'd5: return mcnt[k][0] + mcnt[k][1] + mcnt[k][2] + mcnt[k][3];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
      mrd[k] = 0;
    end
    mcyc   = 0;
    mstate = 0;
  endtask

  task automatic model_step(input logic [5:0] op, input logic valid, input logic halt,
                            input logic clr, input logic [2:0] sel);
    for (int k = 0; k < 2; k++) mrd[k] = readout(k, sel);
    if (clr) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
      mcyc   = 0;
      mstate = 0;
    end else begin
      if (mstate != 2 && valid)
        for (int k = 0; k < 2; k++)
          if (mcnt[k][op_class(op)] < mmax[k]) mcnt[k][op_class(op)]++;
      if (mstate == 1 && mcyc != 32'hffff_ffff) mcyc++;
      if (mstate == 0)                mstate = halt ? 2 : (valid ? 1 : 0);
      else if (mstate == 1 && halt)   mstate = 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic check_all();
    chk("state",   32'(b16.state),   mstate);
    chk("state4",  32'(b4.state),    mstate);
    chk("cyc",     b16.cyc_cnt,      mcyc);
    chk("cyc4",    b4.cyc_cnt,       mcyc);
    chk("r16",     32'(b16.r_cnt),   mcnt[0][0]);
    chk("i16",     32'(b16.i_cnt),   mcnt[0][1]);
    chk("j16",     32'(b16.j_cnt),   mcnt[0][2]);
    chk("o16",     32'(b16.o_cnt),   mcnt[0][3]);
    chk("rd16",    b16.rd_data,      mrd[0]);
    chk("r4",      32'(b4.r_cnt),    mcnt[1][0]);
    chk("i4",      32'(b4.i_cnt),    mcnt[1][1]);
    chk("j4",      32'(b4.j_cnt),    mcnt[1][2]);
    chk("o4",      32'(b4.o_cnt),    mcnt[1][3]);
    chk("rd4",     b4.rd_data,       mrd[1]);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic drive(input logic [5:0] op, input logic valid, input logic halt,
                       input logic clr, input logic [2:0] sel);
    b16.op = op; b16.valid = valid; b16.halt = halt; b16.clr = clr; b16.sel = sel;
    b4.op  = op; b4.valid  = valid; b4.halt  = halt; b4.clr  = clr; b4.sel  = sel;
    @(posedge clk);
    model_step(op, valid, halt, clr, sel);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(b16.state), 32'd0);
    chk({tag, "_r"},     32'(b16.r_cnt), 32'd0);
    chk({tag, "_i"},     32'(b16.i_cnt), 32'd0);
    chk({tag, "_cyc"},   b16.cyc_cnt,    32'd0);
    chk({tag, "_rd"},    b16.rd_data,    32'd0);
    chk({tag, "_r4"},    32'(b4.r_cnt),  32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mmax[0] = 32'h0000_ffff;
    mmax[1] = 32'd15;
    op_pool = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10,
                6'd12, 6'd13, 6'd35, 6'd43, 6'd63, 6'd1};
    b16.op = '0; b16.valid = 1'b0; b16.halt = 1'b0; b16.clr = 1'b0; b16.sel = '0;
    b4.op  = '0; b4.valid  = 1'b0; b4.halt  = 1'b0; b4.clr  = 1'b0; b4.sel  = '0;
    model_reset();

    // Power-on reset
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("por");
    #11 rst_n = 1'b1;

    // Four mixed retirements from IDLE
    drive(6'b000000, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(6'b100011, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(6'b000010, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(6'b111111, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("seq4_r",     32'(b16.r_cnt), 32'd1);
    chk("seq4_i",     32'(b16.i_cnt), 32'd1);
    chk("seq4_j",     32'(b16.j_cnt), 32'd1);
    chk("seq4_o",     32'(b16.o_cnt), 32'd1);
    chk("seq4_state", 32'(b16.state), 32'd1);
    chk("seq4_cyc",   b16.cyc_cnt,    32'd3);

    // Halt together with a retiring I-type, then frozen while HALTED
    drive(6'b001000, 1'b1, 1'b1, 1'b0, 3'd2);
    chk("halt_i",     32'(b16.i_cnt), 32'd2);
    chk("halt_state", 32'(b16.state), 32'd2);
    for (int n = 0; n < 10; n++)
      drive(op_pool[$urandom_range(13, 0)], 1'b1, 1'($urandom_range(1, 0)), 1'b0, 3'($urandom_range(7, 0)));
    chk("frozen_i", 32'(b16.i_cnt), 32'd2);
    chk("frozen_cyc", b16.cyc_cnt, 32'd4);

    // clr beats valid in HALTED
    drive(6'b000000, 1'b1, 1'b0, 1'b1, 3'd1);
    chk("clr_state", 32'(b16.state), 32'd0);
    chk("clr_r",     32'(b16.r_cnt), 32'd0);

    // Saturation of the 4-bit instance; total readout stays at 15
    for (int n = 0; n < 17; n++) drive(6'b000000, 1'b1, 1'b0, 1'b0, 3'd1);
    drive(6'b000000, 1'b0, 1'b0, 1'b0, 3'd5);
    drive(6'b000000, 1'b0, 1'b0, 1'b0, 3'd5);
    chk("sat_r4",   32'(b4.r_cnt), 32'd15);
    chk("sat_tot4", b4.rd_data,    32'd15);
    chk("sat_r16",  32'(b16.r_cnt), 32'd17);

    // Readout latency: sel 1 then 3
    drive(6'b000011, 1'b1, 1'b0, 1'b0, 3'd1);
    drive(6'b000011, 1'b1, 1'b0, 1'b0, 3'd1);
    chk("lat_r", b16.rd_data, 32'd17);
    drive(6'b000000, 1'b0, 1'b0, 1'b0, 3'd3);
    chk("lat_j", b16.rd_data, 32'd2);

    // Asynchronous reset between edges mid-RUN
    drive(6'b001101, 1'b1, 1'b0, 1'b0, 3'd2);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    model_reset();
    #2 rst_n = 1'b1;
    drive(6'b000000, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("arst_idle", 32'(b16.state), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [5:0] rop;
      rop = ($urandom_range(3, 0) == 0) ? 6'($urandom_range(63, 0)) : op_pool[$urandom_range(13, 0)];
      drive(rop, 1'($urandom_range(3, 0) != 0), ($urandom_range(59, 0) == 0),
            ($urandom_range(39, 0) == 0), 3'($urandom_range(7, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
